// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: GREEN -> YELLOW -> RED phase sequencer that drives the
// light_counter load/count interface (one-hot init pulse, en while running,
// last to advance) and the one-hot lamp outputs {red, yellow, green}.
//
// Optional feature macro: TLC_PED_TRUNC_EN
//   defined   : a latched pedestrian request truncates green while the
//               remaining count is above pPED_MIN_GREEN.
//   undefined : ped_req is ignored and ped_pending stays 0.
//
// Every output is a register loaded from a decode of the next state, so the
// lamps, init and en change on the same edge as the state.
module traffic_light_ctrl #(
  parameter int pINIT_WIDTH    = 3,
  parameter int pCNT_WIDTH     = 5,
  parameter int pPED_MIN_GREEN = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   last,
  input  logic [pCNT_WIDTH-1:0]  cnt_in,
  input  logic                   ped_req,
  output logic [pINIT_WIDTH-1:0] init,
  output logic                   en,
  output logic [2:0]             lights,
  output logic                   cycle_done,
  output logic                   ped_pending
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_G = 3'd1,
    RUN_G  = 3'd2,
    LOAD_Y = 3'd3,
    RUN_Y  = 3'd4,
    LOAD_R = 3'd5,
    RUN_R  = 3'd6
  } state_t;

  // Lamp encodings, {red, yellow, green}
  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  // Phase index used to select the init bit: 0 = GREEN, 1 = YELLOW, 2 = RED
  localparam logic [1:0] SEL_G = 2'd0;
  localparam logic [1:0] SEL_Y = 2'd1;
  localparam logic [1:0] SEL_R = 2'd2;

  state_t                 state_reg, state_next;
  logic [pINIT_WIDTH-1:0] init_reg, init_next;
  logic                   en_reg, en_next;
  logic [2:0]             lights_reg, lights_next;
  logic                   cycle_done_reg, cycle_done_next;
  logic                   ped_pending_reg, ped_pending_next;

  logic                   load_next;
  logic [1:0]             load_sel_next;
  logic                   green_trunc;

`ifdef TLC_PED_TRUNC_EN
  // Cut green short only while enough of it remains to be worth cutting
  assign green_trunc = ped_pending_reg && (cnt_in > pCNT_WIDTH'(pPED_MIN_GREEN));

  // Latch requests; entering LOAD_R serves the request, but a request that
  // arrives on that same edge is kept for the next cycle
  always_comb begin
    ped_pending_next = ped_pending_reg | ped_req;
    if (state_next == LOAD_R && state_reg != LOAD_R) begin
      ped_pending_next = ped_req;
    end
  end
`else
  logic unused_ped_inputs;
  assign unused_ped_inputs = ^{cnt_in, ped_req};
  assign green_trunc       = 1'b0;

  // Pedestrian handling is compiled out: the latch stays clear
  always_comb begin
    ped_pending_next = 1'b0;
  end
`endif

  // Next-state selection and decode of the registered outputs from it
  always_comb begin
    state_next      = state_reg;
    load_next       = 1'b0;
    load_sel_next   = SEL_G;
    en_next         = 1'b0;
    lights_next     = LAMP_R;
    cycle_done_next = 1'b0;

    case (state_reg)
      IDLE:   if (run) state_next = LOAD_G;
      LOAD_G: state_next = RUN_G;
      RUN_G:  if (last || green_trunc) state_next = LOAD_Y;
      LOAD_Y: state_next = RUN_Y;
      RUN_Y:  if (last) state_next = LOAD_R;
      LOAD_R: state_next = RUN_R;
      RUN_R: begin
        if (last) begin
          cycle_done_next = 1'b1;
          state_next      = run ? LOAD_G : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      LOAD_G: begin
        load_next     = 1'b1;
        load_sel_next = SEL_G;
        lights_next   = LAMP_G;
      end
      RUN_G: begin
        en_next     = 1'b1;
        lights_next = LAMP_G;
      end
      LOAD_Y: begin
        load_next     = 1'b1;
        load_sel_next = SEL_Y;
        lights_next   = LAMP_Y;
      end
      RUN_Y: begin
        en_next     = 1'b1;
        lights_next = LAMP_Y;
      end
      LOAD_R: begin
        load_next     = 1'b1;
        load_sel_next = SEL_R;
        lights_next   = LAMP_R;
      end
      RUN_R: begin
        en_next     = 1'b1;
        lights_next = LAMP_R;
      end
      default: begin
        lights_next = LAMP_R;
      end
    endcase
  end

  // One-hot init decode: only the bit of the phase being loaded is set
  generate
    for (genvar gi = 0; gi < pINIT_WIDTH; gi++) begin : g_init_bit
      assign init_next[gi] = load_next && (load_sel_next == 2'(gi));
    end
  endgenerate

  // State and output registers; reset drops straight to the safe red IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      init_reg        <= '0;
      en_reg          <= 1'b0;
      lights_reg      <= LAMP_R;
      cycle_done_reg  <= 1'b0;
      ped_pending_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      init_reg        <= init_next;
      en_reg          <= en_next;
      lights_reg      <= lights_next;
      cycle_done_reg  <= cycle_done_next;
      ped_pending_reg <= ped_pending_next;
    end
  end

  assign init        = init_reg;
  assign en          = en_reg;
  assign lights      = lights_reg;
  assign cycle_done  = cycle_done_reg;
  assign ped_pending = ped_pending_reg;

endmodule
